// File: rtl/spi_slave_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_fifo_pkg
// Brief    : Shared types and sizing helpers for the SPI slave FIFOs
// Revision : 1.0 - initial release
// ============================================================================
package spi_slave_fifo_pkg;

    // Pointer update operation; clear dominates increment.
    typedef enum logic [1:0] {
        PTR_HOLD = 2'd0,
        PTR_INC  = 2'd1,
        PTR_CLR  = 2'd2
    } ptr_op_e;

    // Width needed to hold a count in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address 0..depth-1 (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_fifo_ptr
// Brief    : Wrapping pointer counter 0..DEPTH-1 with synchronous clear
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_fifo_ptr
    import spi_slave_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);

    ptr_op_e          w_op;
    logic [PTR_W-1:0] r_ptr;

    // Select the pointer operation for this cycle.
    always_comb begin
        w_op = PTR_HOLD;
        if (clr_i) begin
            w_op = PTR_CLR;
        end else if (inc_i) begin
            w_op = PTR_INC;
        end
    end

    // Pointer register; wraps by explicit compare so any depth works.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            case (w_op)
                PTR_CLR: r_ptr <= '0;
                PTR_INC: r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
                default: r_ptr <= r_ptr;
            endcase
        end
    end

    assign ptr_o = r_ptr;

endmodule
`default_nettype wire

// File: rtl/spi_slave_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_sync_fifo
// Brief    : Single-clock FIFO with optional fall-through, fill level,
//            almost-full/almost-empty flags and synchronous flush
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_sync_fifo
    import spi_slave_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter bit FALL_THROUGH = 1'b0,
    parameter int CNT_W        = cnt_w(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_W-1:0]      level_o,
    input  logic [CNT_W-1:0]      afull_thr_i,
    input  logic [CNT_W-1:0]      aempty_thr_i,
    output logic                  afull_o,
    output logic                  aempty_o
);

    localparam int               c_ptr_w = ptr_w(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [CNT_W-1:0]      r_cnt;
    logic [c_ptr_w-1:0]    w_wr_ptr;
    logic [c_ptr_w-1:0]    w_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == c_full);

    // Ready depends only on stored state and flush, never on ready_i.
    assign ready_o = ~w_full & ~flush_i;

    generate
        if (FALL_THROUGH) begin : g_fall_through
            // An empty FIFO presents the incoming word directly.
            assign valid_o  = (~w_empty | valid_i) & ~flush_i;
            assign data_o   = w_empty ? data_i : r_mem[w_rd_ptr];
            // Word consumed in the same cycle never touches storage.
            assign w_bypass = w_empty & valid_i & ready_i & ~flush_i;
        end else begin : g_registered
            assign valid_o  = ~w_empty & ~flush_i;
            assign data_o   = r_mem[w_rd_ptr];
            assign w_bypass = 1'b0;
        end
    endgenerate

    // Storage operations; a bypassed word is neither written nor read.
    assign w_push = valid_i & ready_o & ~w_bypass;
    assign w_pop  = valid_o & ready_i & ~w_empty;

    spi_slave_fifo_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (c_ptr_w)
    ) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (w_push),
        .ptr_o (w_wr_ptr)
    );

    spi_slave_fifo_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (c_ptr_w)
    ) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (w_pop),
        .ptr_o (w_rd_ptr)
    );

    // Write port of the storage array; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= data_i;
        end
    end

    // Occupancy counter; flush clears it regardless of push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign level_o  = r_cnt;
    assign afull_o  = (r_cnt >= afull_thr_i);
    assign aempty_o = (r_cnt <= aempty_thr_i);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_sync_fifo
// Brief    : Directed self-checking bench with scoreboard queues
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: depth 8, registered output
    logic        a_flush = 0, a_valid_i = 0, a_ready_i = 0;
    logic [31:0] a_data_i = '0;
    logic        a_ready_o, a_valid_o, a_afull, a_aempty;
    logic [31:0] a_data_o;
    logic [3:0]  a_level, a_afull_thr = 4'd0, a_aempty_thr = 4'd0;

    // Instance B: depth 5, registered output
    logic        b_valid_i = 0, b_ready_i = 0;
    logic [31:0] b_data_i = '0;
    logic        b_ready_o, b_valid_o, b_afull, b_aempty;
    logic [31:0] b_data_o;
    logic [2:0]  b_level;

    // Instance C: depth 8, fall-through
    logic        c_valid_i = 0, c_ready_i = 0;
    logic [31:0] c_data_i = '0;
    logic        c_ready_o, c_valid_o, c_afull, c_aempty;
    logic [31:0] c_data_o;
    logic [3:0]  c_level;

    spi_slave_sync_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(8), .FALL_THROUGH(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .data_i(a_data_i), .valid_i(a_valid_i),
        .ready_o(a_ready_o), .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .level_o(a_level), .afull_thr_i(a_afull_thr), .aempty_thr_i(a_aempty_thr),
        .afull_o(a_afull), .aempty_o(a_aempty));

    spi_slave_sync_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(5), .FALL_THROUGH(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .data_i(b_data_i), .valid_i(b_valid_i),
        .ready_o(b_ready_o), .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .level_o(b_level), .afull_thr_i(3'd5), .aempty_thr_i(3'd0),
        .afull_o(b_afull), .aempty_o(b_aempty));

    spi_slave_sync_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(8), .FALL_THROUGH(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .data_i(c_data_i), .valid_i(c_valid_i),
        .ready_o(c_ready_o), .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .level_o(c_level), .afull_thr_i(4'd8), .aempty_thr_i(4'd0),
        .afull_o(c_afull), .aempty_o(c_aempty));

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3;
        chk("rst_ready",  a_ready_o, 1);
        chk("rst_valid",  a_valid_o, 0);
        chk("rst_level",  a_level,   0);
        chk("rst_aempty", a_aempty,  1);
        chk("rst_afull_thr0", a_afull, 1);
        a_afull_thr = 4'd6;
        #1;
        chk("rst_afull_thr6", a_afull, 0);
        a_aempty_thr = 4'd1;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- fill A with 1..8, flags per level ----------------
        a_ready_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            a_valid_i = 1'b1;
            a_data_i  = 32'(k);
            #3;
            chk("fill_ready",  a_ready_o, 1);
            chk("fill_level",  a_level,   k - 1);
            chk("fill_aempty", a_aempty,  (k - 1) <= 1);
            chk("fill_afull",  a_afull,   (k - 1) >= 6);
            qa.push_back(32'(k));
            tick();
        end
        a_valid_i = 1'b0;
        #3;
        chk("full_ready",  a_ready_o, 0);
        chk("full_level",  a_level,   8);
        chk("full_afull",  a_afull,   1);
        chk("full_aempty", a_aempty,  0);
        chk("full_valid",  a_valid_o, 1);

        // ---------------- full: push+pop -> pop only ----------------
        a_valid_i = 1'b1;
        a_data_i  = 32'h99;
        a_ready_i = 1'b1;
        #3;
        exp_w = qa.pop_front();
        chk("fullpp_data",  a_data_o,  exp_w);
        chk("fullpp_ready", a_ready_o, 0);
        tick();
        a_valid_i = 1'b0;
        a_ready_i = 1'b0;
        #3;
        chk("fullpp_level", a_level,   7);
        chk("fullpp_ready_after", a_ready_o, 1);

        // ---------------- drain remaining words ----------------
        a_ready_i = 1'b1;
        while (qa.size() > 0) begin
            #3;
            exp_w = qa.pop_front();
            chk("drain_valid", a_valid_o, 1);
            chk("drain_data",  a_data_o,  exp_w);
            tick();
        end
        a_ready_i = 1'b0;
        #3;
        chk("drain_valid_end", a_valid_o, 0);
        chk("drain_level_end", a_level,   0);
        tick();

        // ---------------- flush at level 6 with concurrent push ----------------
        for (int k = 0; k < 6; k++) begin
            a_valid_i = 1'b1;
            a_data_i  = 32'h100 + 32'(k);
            tick();
        end
        a_data_i = 32'hDEAD;
        a_flush  = 1'b1;
        #3;
        chk("flush_level_before", a_level,   6);
        chk("flush_valid_during", a_valid_o, 0);
        chk("flush_ready_during", a_ready_o, 0);
        tick();
        a_flush   = 1'b0;
        a_valid_i = 1'b0;
        #3;
        chk("flush_level", a_level,   0);
        chk("flush_valid", a_valid_o, 0);
        a_valid_i = 1'b1;
        a_data_i  = 32'h55;
        tick();
        a_valid_i = 1'b0;
        #3;
        chk("postflush_data",  a_data_o, 32'h55);
        chk("postflush_level", a_level,  1);
        a_ready_i = 1'b1;
        tick();
        a_ready_i = 1'b0;

        // ---------------- B: depth 5 streaming, 20 words ----------------
        for (int k = 0; k < 20; k++) begin
            b_valid_i = 1'b1;
            b_data_i  = 32'hB000_0000 + 32'(k * 7 + 3);
            b_ready_i = (k != 0);
            #3;
            if (k != 0) begin
                exp_w = qb.pop_front();
                chk("stream_valid", b_valid_o, 1);
                chk("stream_data",  b_data_o,  exp_w);
                chk("stream_level", b_level,   1);
                chk("stream_ready", b_ready_o, 1);
            end
            qb.push_back(b_data_i);
            tick();
        end
        b_valid_i = 1'b0;
        #3;
        exp_w = qb.pop_front();
        chk("stream_last_data", b_data_o, exp_w);
        tick();
        b_ready_i = 1'b0;
        #3;
        chk("stream_empty", b_valid_o, 0);
        chk("stream_level_end", b_level, 0);
        tick();

        // ---------------- C: fall-through bypass ----------------
        c_valid_i = 1'b1;
        c_data_i  = 32'hA5A5A5A5;
        c_ready_i = 1'b1;
        #3;
        chk("ft_valid", c_valid_o, 1);
        chk("ft_data",  c_data_o,  32'hA5A5A5A5);
        tick();
        c_valid_i = 1'b0;
        c_ready_i = 1'b0;
        #3;
        chk("ft_level", c_level,   0);
        chk("ft_valid_after", c_valid_o, 0);
        // Empty, consumer stalled: word is shown at once and also stored.
        c_valid_i = 1'b1;
        c_data_i  = 32'h77;
        #3;
        chk("ft_stall_valid", c_valid_o, 1);
        chk("ft_stall_data",  c_data_o,  32'h77);
        tick();
        c_valid_i = 1'b0;
        c_data_i  = 32'h1234;
        #3;
        chk("ft_stall_level", c_level,  1);
        chk("ft_stall_hold",  c_data_o, 32'h77);
        c_ready_i = 1'b1;
        tick();
        c_ready_i = 1'b0;
        #3;
        chk("ft_stall_drained", c_level, 0);

        // ---------------- asynchronous reset mid-fill ----------------
        tick();
        for (int k = 0; k < 3; k++) begin
            a_valid_i = 1'b1;
            a_data_i  = 32'h300 + 32'(k);
            tick();
        end
        a_valid_i = 1'b0;
        #1;
        chk("arst_level_before", a_level, 3);
        rst = 1'b1;
        #1;
        chk("arst_valid", a_valid_o, 0);
        chk("arst_level", a_level,   0);
        chk("arst_ready", a_ready_o, 1);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
